// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, polarity levels and the aligned sync-bundle type
// used by the timing generator and its output delay line.
package vga_timing_pkg;

  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_PULSE  = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_PULSE  = 2;
  localparam int VGA_V_BP     = 33;
  localparam logic VGA_H_POL  = POL_ACTIVE_LOW;
  localparam logic VGA_V_POL  = POL_ACTIVE_LOW;

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_PULSE  = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_PULSE  = 4;
  localparam int SVGA_V_BP     = 23;
  localparam logic SVGA_H_POL  = POL_ACTIVE_HIGH;
  localparam logic SVGA_V_POL  = POL_ACTIVE_HIGH;

  // Bundle kept together through the delay line so all five stay aligned.
  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic active;
    logic line_start;
    logic frame_start;
  } vga_sync_t;

  function automatic int h_total(input int active, input int fp, input int pulse, input int bp);
    return active + fp + pulse + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int pulse, input int bp);
    return active + fp + pulse + bp;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register for the aligned sync bundle; DEPTH=0 is a
// straight pass-through so the top needs no special casing.
module sync_delay_line #(
  parameter int               WIDTH     = 5,
  parameter int               DEPTH     = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
      if (en) begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_timing_gen.sv
// Parametrised VGA timing generator: column/row counters, sync/active window
// decode registered one pixel behind the counters, optional aligned delay.
module vga_sync_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = VGA_H_ACTIVE,
  parameter int   H_FP       = VGA_H_FP,
  parameter int   H_PULSE    = VGA_H_PULSE,
  parameter int   H_BP       = VGA_H_BP,
  parameter int   V_ACTIVE   = VGA_V_ACTIVE,
  parameter int   V_FP       = VGA_V_FP,
  parameter int   V_PULSE    = VGA_V_PULSE,
  parameter int   V_BP       = VGA_V_BP,
  parameter logic H_POL      = VGA_H_POL,
  parameter logic V_POL      = VGA_V_POL,
  parameter int   SYNC_DELAY = 0,
  localparam int  H_TOTAL    = h_total(H_ACTIVE, H_FP, H_PULSE, H_BP),
  localparam int  V_TOTAL    = v_total(V_ACTIVE, V_FP, V_PULSE, V_BP),
  localparam int  CW         = $clog2(H_TOTAL),
  localparam int  RW         = $clog2(V_TOTAL)
) (
  input  logic          CLK,
  input  logic          i_Reset,
  input  logic          i_Pix_En,
  output logic          o_H_Sync,
  output logic          o_V_Sync,
  output logic          o_Active,
  output logic [CW-1:0] o_Col,
  output logic [RW-1:0] o_Row,
  output logic          o_Line_Start,
  output logic          o_Frame_Start
);

  if (H_FP < 1 || H_PULSE < 1 || H_BP < 1 || V_FP < 1 || V_PULSE < 1 || V_BP < 1 ||
      SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_params
    $error("vga_sync_timing_gen: porch/pulse widths must be nonzero and SYNC_DELAY within 0..7");
  end

  localparam logic [CW-1:0] COL_LAST    = CW'(H_TOTAL - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(V_TOTAL - 1);
  localparam logic [CW-1:0] COL_ACT_END = CW'(H_ACTIVE);
  localparam logic [RW-1:0] ROW_ACT_END = RW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START    = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END      = CW'(H_ACTIVE + H_FP + H_PULSE);
  localparam logic [RW-1:0] VS_START    = RW'(V_ACTIVE + V_FP);
  localparam logic [RW-1:0] VS_END      = RW'(V_ACTIVE + V_FP + V_PULSE);

  localparam vga_sync_t SYNC_IDLE = '{h_sync: ~H_POL, v_sync: ~V_POL, active: 1'b0,
                                      line_start: 1'b0, frame_start: 1'b0};

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  vga_sync_t     decode;
  vga_sync_t     sync_q, sync_d;
  vga_sync_t     sync_out;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_Pix_En) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Row only moves on the column wrap, so v_sync naturally changes at line start.
  always_comb begin
    decode             = SYNC_IDLE;
    decode.h_sync      = (col_q >= HS_START && col_q < HS_END) ? H_POL : ~H_POL;
    decode.v_sync      = (row_q >= VS_START && row_q < VS_END) ? V_POL : ~V_POL;
    decode.active      = (col_q < COL_ACT_END) && (row_q < ROW_ACT_END);
    decode.line_start  = (col_q == '0);
    decode.frame_start = (col_q == '0) && (row_q == '0);
    sync_d             = i_Pix_En ? decode : sync_q;
  end

  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      col_q  <= '0;
      row_q  <= '0;
      sync_q <= SYNC_IDLE;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      sync_q <= sync_d;
    end
  end

  sync_delay_line #(
    .WIDTH     ($bits(vga_sync_t)),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk  (CLK),
    .rst  (i_Reset),
    .en   (i_Pix_En),
    .din  (sync_q),
    .dout (sync_out)
  );

  assign o_Col         = col_q;
  assign o_Row         = row_q;
  assign o_H_Sync      = sync_out.h_sync;
  assign o_V_Sync      = sync_out.v_sync;
  assign o_Active      = sync_out.active;
  assign o_Line_Start  = sync_out.line_start;
  assign o_Frame_Start = sync_out.frame_start;

endmodule
